priority_encoder: RTL and testbench
===================================

Name: priority_encoder

Overview:
- Registered N-input priority encoder. The highest-index asserted request bit wins.
- Outputs the binary index of the winner plus a valid flag, one clock after the input is sampled.
- Used wherever a request vector is reduced to a single grant index, e.g. interrupt or arbiter front-ends.
- Purely datapath: no handshake and no internal state beyond the output registers.

Parameters:
- N, 4, number of request inputs. Legal range 2..64; any value outside this range is a build-time error.
- YW, $clog2(N) (localparam, not overridable), width of the index output. YW=2 for N=4.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  asynchronous active-low reset.
- I  input  N  request vector; bit k = request k. Bit N-1 has the highest priority.
- Y  output  YW  registered binary index of the highest-priority asserted bit of I.
- valid  output  1  registered flag: 1 when at least one bit of I was asserted at the sampling edge.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, Y=0 and valid=0 immediately, independent of clk. Both hold until the first rising clk edge after rst_n deasserts.
- Reset deassertion is not synchronised inside the block. The system guarantees release away from the clk edge.
- Sampling: at every rising clk edge with rst_n=1, I is sampled and the outputs update:
  - valid <= |I
  - Y <= largest k such that I[k]=1
- Latency: exactly 1 cycle. Outputs reflect I as sampled at the preceding rising edge. There is no combinational path from I to Y or valid.
- Throughput: a new input is accepted every cycle. There is no enable and no stall.
- All-zero input: valid=0 and Y=0. Y is forced to 0, not held from the previous value.
- Priority is strictly fixed by index, with no rotation or fairness:
  - any bit pattern with I[N-1]=1 gives Y=N-1
  - lower bits are ignored whenever a higher bit is set
- Single-bit inputs encode to their index: I=1<<k gives Y=k, valid=1.
- Unknown (X/Z) bits on I are not required to be handled. The bench drives only 0/1.
- Reset mid-operation: asserting rst_n clears Y and valid asynchronously in the same instant. The next valid result appears one edge after release, using I sampled at that edge.
- Implementation: the encoder logic is a loop scanning from bit 0 upward, where later (higher) hits overwrite earlier ones. Any structure with equivalent behaviour is acceptable. Output registers are plain flops with async clear.
- Synthesis: the design is fully synthesisable, with no latches and no initial blocks.

Test Plan:
- Reset: drive I=4'b1111 and hold rst_n=0 across several edges -> Y=0, valid=0 throughout. Release rst_n -> after the next edge, Y=3, valid=1.
- No request: I=4'b0000 -> after one edge, Y=0, valid=0.
- Single bits: I=0001, 0010, 0100, 1000, applied on consecutive cycles -> Y=0, 1, 2, 3 respectively, each one cycle later, with valid=1 each time.
- Multiple bits: I=1010 -> Y=3. I=0111 -> Y=2. I=1111 -> Y=3. valid=1 for all three.
- Latency and back-to-back: change I every cycle (0001 -> 1000 -> 0000) -> Y and valid trail I by exactly one edge (Y 0 -> 3 -> 0, valid 1 -> 1 -> 0). Y never changes between clk edges.
- Async reset mid-stream: with valid=1, pulse rst_n low between edges -> Y and valid go to 0 before the next edge. They recover one edge after release.

Source files
------------

// File: rtl/priority_encoder.sv
// Registered N-input priority encoder: highest-index asserted request wins.
// Outputs the winner's binary index and a valid flag one clock after sampling.
module priority_encoder #(
  parameter  int unsigned N  = 4,
  localparam int unsigned YW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  I,
  output logic [YW-1:0] Y,
  output logic          valid
);

  // Reject unsupported request-vector widths at elaboration
  if ((N < 2) || (N > 64)) begin : g_bad_n
    $error("priority_encoder: N=%0d outside legal range 2..64", N);
  end

  logic [YW-1:0] y_d;
  logic [YW-1:0] y_q;
  logic          valid_d;
  logic          valid_q;

  // Upward scan so higher-index hits overwrite lower ones; all-zero gives index 0
  always_comb begin
    y_d     = '0;
    valid_d = |I;
    for (int unsigned k = 0; k < N; k++) begin
      if (I[k]) begin
        y_d = YW'(k);
      end
    end
  end

  // Output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder (N=4): stimulus pushes expected
// results, a monitor pops and compares one edge later.
module tb_priority_encoder;

  localparam int unsigned N  = 4;
  localparam int unsigned YW = 2;

  typedef struct packed {
    logic [YW-1:0] y;
    logic          v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  I;
  logic [YW-1:0] Y;
  logic          valid;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  priority_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (I),
    .Y     (Y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [YW-1:0] ay, input logic av,
                     input logic [YW-1:0] ey, input logic ev);
    checks++;
    if ((ay !== ey) || (av !== ev)) begin
      errors++;
      $display("FAIL %s: got Y=%0d valid=%0b, want Y=%0d valid=%0b", name, ay, av, ey, ev);
    end
  endtask

  // Drive a vector at the falling edge; outputs must still show the previous result
  task automatic apply(input logic [N-1:0] vec, input logic [YW-1:0] ey, input logic ev);
    exp_t e;
    @(negedge clk);
    I = vec;
    e.y = ey;
    e.v = ev;
    exp_q.push_back(e);
    #1;
    chk("no_comb_path", Y, valid, last_exp.y, last_exp.v);
    last_exp = e;
  endtask

  // Monitor: compare each presented result against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sampled_result", Y, valid, e.y, e.v);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    I        = 4'b1111;
    last_exp = '0;

    // Reset held across edges with all requests asserted
    #1;
    chk("reset_async", Y, valid, 2'd0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_hold", Y, valid, 2'd0, 1'b0);
    end

    // Release reset at the falling edge; first result after the next edge
    @(negedge clk);
    rst_n = 1'b1;
    begin
      exp_t e;
      e.y = 2'd3;
      e.v = 1'b1;
      exp_q.push_back(e);
      last_exp = e;
    end

    // No request
    apply(4'b0000, 2'd0, 1'b0);
    // Single bits
    apply(4'b0001, 2'd0, 1'b1);
    apply(4'b0010, 2'd1, 1'b1);
    apply(4'b0100, 2'd2, 1'b1);
    apply(4'b1000, 2'd3, 1'b1);
    // Multiple bits
    apply(4'b1010, 2'd3, 1'b1);
    apply(4'b0111, 2'd2, 1'b1);
    apply(4'b1111, 2'd3, 1'b1);
    apply(4'b0110, 2'd2, 1'b1);
    apply(4'b0011, 2'd1, 1'b1);
    // Back-to-back changes, including return to zero (Y forced to 0)
    apply(4'b0001, 2'd0, 1'b1);
    apply(4'b1000, 2'd3, 1'b1);
    apply(4'b0000, 2'd0, 1'b0);
    apply(4'b1001, 2'd3, 1'b1);

    // Mid-stream async reset pulsed between edges while valid=1
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_midstream", Y, valid, 2'd0, 1'b0);
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    I     = 4'b0100;
    begin
      exp_t e;
      e.y = 2'd2;
      e.v = 1'b1;
      exp_q.push_back(e);
      last_exp = e;
    end
    apply(4'b0000, 2'd0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
